// File: rtl/reg_file_mp_if.sv
// Register file bus: write port, NUM_RD packed read ports and clear-sequencer control/status.
// Ports (as seen from the register file, modport slave):
//   regWrite, writeReg, writeData : write request
//   readReg / regData              : packed read addresses / read data, port i at slice i
//   clear_req                      : request full-array clear
//   busy, clear_done, wr_drop      : sequencer status and dropped-write flag
interface reg_file_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic                     regWrite;
  logic [ADDR_W-1:0]        writeReg;
  logic [DATA_W-1:0]        writeData;
  logic [NUM_RD*ADDR_W-1:0] readReg;
  logic [NUM_RD*DATA_W-1:0] regData;
  logic                     clear_req;
  logic                     busy;
  logic                     clear_done;
  logic                     wr_drop;

  modport master (
    output regWrite, writeReg, writeData, readReg, clear_req,
    input  regData, busy, clear_done, wr_drop
  );

  modport slave (
    input  regWrite, writeReg, writeData, readReg, clear_req,
    output regData, busy, clear_done, wr_drop
  );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with a self-timed clear sequencer.
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset; starts a clear sweep
//   bus   : reg_file_mp_if.slave (write port, NUM_RD combinational read ports,
//           clear_req in, busy/clear_done/wr_drop out)
// Optional macro WRITE_BYPASS_EN: write-first forwarding of an accepted write onto any read
// port addressing the same entry in the same cycle. Undefined: reads return the old contents.
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] ptrQ, ptrD;
  logic              doneQ, doneD;
  logic [DATA_W-1:0] memQ [DEPTH];

  logic busy;
  logic wrZeroAddr;
  logic wrAccept;

  assign busy       = (stateQ == StSweep);
  assign wrZeroAddr = (ZERO_REG != 0) && (bus.writeReg == '0);
  assign wrAccept   = bus.regWrite && !busy && !wrZeroAddr;

  assign bus.busy       = busy;
  assign bus.clear_done = doneQ;
  // Writes to the hardwired zero entry are silent, so only the sweep raises wr_drop.
  assign bus.wr_drop    = bus.regWrite && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StSweep;
      ptrQ   <= '0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      ptrQ   <= ptrD;
      doneQ  <= doneD;
    end
  end

  always_comb begin
    stateD = stateQ;
    ptrD   = ptrQ;
    doneD  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (bus.clear_req) begin
          stateD = StSweep;
          ptrD   = '0;
        end
      end
      StSweep: begin
        // ptr wraps to 0 on the last entry, ready for the next sweep.
        ptrD = ptrQ + 1'b1;
        if (ptrQ == ADDR_W'(DEPTH - 1)) begin
          stateD = StIdle;
          doneD  = 1'b1;
        end
      end
      default: begin
        stateD = StSweep;
        ptrD   = '0;
      end
    endcase
  end

  // Array has no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (busy) begin
      memQ[ptrQ] <= '0;
    end else if (wrAccept) begin
      memQ[bus.writeReg] <= bus.writeData;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] rAddr;
    logic [DATA_W-1:0] rData;

    assign rAddr = bus.readReg[gi*ADDR_W +: ADDR_W];

    always_comb begin
      rData = memQ[rAddr];
      if (busy) begin
        rData = '0;
      end else if ((ZERO_REG != 0) && (rAddr == '0)) begin
        rData = '0;
      end
`ifdef WRITE_BYPASS_EN
      else if (wrAccept && (bus.writeReg == rAddr)) begin
        rData = bus.writeData;
      end
`endif
    end

    assign bus.regData[gi*DATA_W +: DATA_W] = rData;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes expected values, a negedge monitor
// pops and compares them. A second instance with ZERO_REG=0 shares the same stimulus.
module tb_reg_file_mp;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  typedef enum int {KRd0, KRd1, KBusy, KDone, KDrop, KZRd0} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int total = 0;
  int bad   = 0;

`ifdef WRITE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();
  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus0 ();

  assign bus0.regWrite  = bus.regWrite;
  assign bus0.writeReg  = bus.writeReg;
  assign bus0.writeData = bus.writeData;
  assign bus0.readReg   = bus.readReg;
  assign bus0.clear_req = bus.clear_req;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  // Monitor
  item_t       mit;
  logic [31:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mit = sb.pop_front();
      case (mit.kind)
        KRd0:    act = bus.regData[31:0];
        KRd1:    act = bus.regData[63:32];
        KBusy:   act = {31'b0, bus.busy};
        KDone:   act = {31'b0, bus.clear_done};
        KDrop:   act = {31'b0, bus.wr_drop};
        KZRd0:   act = bus0.regData[31:0];
        default: act = 'x;
      endcase
      total++;
      if (act !== mit.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h at %0t", mit.name, act, mit.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string name, input kind_e k, input logic [31:0] v);
    item_t it;
    it.name = name;
    it.kind = k;
    it.exp  = v;
    sb.push_back(it);
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.readReg = {a1, a0};
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [31:0] d);
    bus.regWrite  = 1'b1;
    bus.writeReg  = a;
    bus.writeData = d;
    step();
    bus.regWrite = 1'b0;
  endtask

  // Full DEPTH-cycle sweep starting at the next edge; busy drops with clear_done on edge 32.
  task automatic expect_sweep(input string name);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k < 32) begin
        expect_v({name, "_busy"}, KBusy, 32'd1);
        expect_v({name, "_done"}, KDone, 32'd0);
      end else begin
        expect_v({name, "_busy_end"}, KBusy, 32'd0);
        expect_v({name, "_done_end"}, KDone, 32'd1);
      end
    end
    step();
    expect_v({name, "_done_pulse"}, KDone, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.regWrite  = 1'b0;
    bus.writeReg  = '0;
    bus.writeData = '0;
    bus.readReg   = '0;
    bus.clear_req = 1'b0;

    // Reset and power-up sweep
    step();
    expect_v("rst_busy", KBusy, 32'd1);
    expect_v("rst_done", KDone, 32'd0);
    expect_v("rst_rd0", KRd0, 32'd0);
    step();
    rst_n = 1'b1;
    expect_sweep("init");
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL init_idle_busy: got %b want 0 at %0t", bus.busy, $time);
    end
    total++;
    if (bus.clear_done !== 1'b0) begin
      bad++;
      $display("FAIL init_idle_done: got %b want 0 at %0t", bus.clear_done, $time);
    end

    for (int i = 0; i < 32; i++) begin
      set_rd(AW'(i), AW'(31 - i));
      expect_v("clr_rd0", KRd0, 32'd0);
      expect_v("clr_rd1", KRd1, 32'd0);
      expect_v("clr_zrd0", KZRd0, 32'd0);
      step();
    end

    // Basic write / dual read
    bus.regWrite  = 1'b1;
    bus.writeReg  = 5'd5;
    bus.writeData = 32'hDEADBEEF;
    set_rd(5'd5, 5'd6);
    expect_v("w5_same_cycle", KRd0, Bypass ? 32'hDEADBEEF : 32'h0);
    expect_v("w5_rd6", KRd1, 32'h0);
    expect_v("w5_drop", KDrop, 32'd0);
    step();
    bus.regWrite = 1'b0;
    set_rd(5'd5, 5'd5);
    #1;
    total++;
    if (bus.regData[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL r5_p0_direct: got %h want deadbeef at %0t", bus.regData[31:0], $time);
    end
    total++;
    if (bus.regData[63:32] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL r5_p1_direct: got %h want deadbeef at %0t", bus.regData[63:32], $time);
    end
    expect_v("r5_p0", KRd0, 32'hDEADBEEF);
    expect_v("r5_p1", KRd1, 32'hDEADBEEF);
    step();
    set_rd(5'd6, 5'd5);
    expect_v("r6_p0", KRd0, 32'h0);
    step();

    // Register 0 handling
    bus.regWrite  = 1'b1;
    bus.writeReg  = 5'd0;
    bus.writeData = 32'h12345678;
    set_rd(5'd0, 5'd0);
    expect_v("w0_drop", KDrop, 32'd0);
    expect_v("w0_rd0", KRd0, 32'h0);
    expect_v("w0_zrd0_same", KZRd0, Bypass ? 32'h12345678 : 32'h0);
    step();
    bus.regWrite = 1'b0;
    expect_v("r0_rd0", KRd0, 32'h0);
    expect_v("r0_zrd0", KZRd0, 32'h12345678);
    step();

    // Read-during-write on reg 9
    write_reg(5'd9, 32'h11112222);
    bus.regWrite  = 1'b1;
    bus.writeReg  = 5'd9;
    bus.writeData = 32'h0000BEEF;
    set_rd(5'd9, 5'd9);
    expect_v("rdw9_same", KRd0, Bypass ? 32'h0000BEEF : 32'h11112222);
    step();
    bus.regWrite = 1'b0;
    expect_v("rdw9_after_p0", KRd0, 32'h0000BEEF);
    expect_v("rdw9_after_p1", KRd1, 32'h0000BEEF);
    step();

    // Requested clear with a dropped write and an ignored clear_req
    write_reg(5'd7, 32'hA5A5A5A5);
    set_rd(5'd7, 5'd3);
    expect_v("pre_clr_r7", KRd0, 32'hA5A5A5A5);
    bus.clear_req = 1'b1;
    step();
    for (int c = 1; c <= 32; c++) begin
      bus.clear_req = (c == 10);
      if (c == 4) begin
        bus.regWrite  = 1'b1;
        bus.writeReg  = 5'd3;
        bus.writeData = 32'h33333333;
        expect_v("sweep_drop", KDrop, 32'd1);
      end else begin
        bus.regWrite = 1'b0;
        expect_v("sweep_nodrop", KDrop, 32'd0);
      end
      expect_v("sweep_busy", KBusy, 32'd1);
      expect_v("sweep_done", KDone, 32'd0);
      expect_v("sweep_rd0", KRd0, 32'h0);
      step();
    end
    bus.regWrite  = 1'b0;
    bus.clear_req = 1'b0;
    total++;
    if (bus.clear_done !== 1'b1) begin
      bad++;
      $display("FAIL clr_end_done_direct: got %b want 1 at %0t", bus.clear_done, $time);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL clr_end_busy_direct: got %b want 0 at %0t", bus.busy, $time);
    end
    expect_v("clr_end_busy", KBusy, 32'd0);
    expect_v("clr_end_done", KDone, 32'd1);
    expect_v("clr_r7", KRd0, 32'h0);
    expect_v("clr_r3", KRd1, 32'h0);
    step();
    expect_v("clr_done_pulse", KDone, 32'd0);

    // Reset mid-sweep at ptr=17
    write_reg(5'd20, 32'h20202020);
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    repeat (17) step();
    rst_n = 1'b0;
    expect_v("abort_busy0", KBusy, 32'd1);
    expect_v("abort_done0", KDone, 32'd0);
    step();
    expect_v("abort_busy1", KBusy, 32'd1);
    step();
    expect_v("abort_busy2", KBusy, 32'd1);
    expect_v("abort_done2", KDone, 32'd0);
    rst_n = 1'b1;
    expect_sweep("restart");
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_idle_busy: got %b want 0 at %0t", bus.busy, $time);
    end
    set_rd(5'd20, 5'd9);
    expect_v("restart_r20", KRd0, 32'h0);
    expect_v("restart_r9", KRd1, 32'h0);
    step();

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
